// File: rtl/seg7_scan_decoder.sv
// Receive-side decoder for a multiplexed active-low 7-segment bus: qualifies each
// scanned digit for STABLE_CYCLES samples and assembles a frame of hex nibbles.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   dig_n,
  output logic [4*NUM_DIGITS-1:0] frame_value,
  output logic                    frame_valid,
  output logic                    frame_err,
  output logic [NUM_DIGITS-1:0]   digit_err
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);
  localparam logic [NUM_DIGITS-1:0] DONE = NUM_DIGITS'(1);

  logic [6:0]              prev_seg_reg;
  logic [NUM_DIGITS-1:0]   prev_dig_reg;
  logic [CW-1:0]           cnt_reg, cnt_next;
  logic [3:0]              slot_reg [NUM_DIGITS];
  logic [3:0]              slot_next [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   err_reg, err_next;
  logic [NUM_DIGITS-1:0]   cap_reg, cap_next, cap_or;
  logic [4*NUM_DIGITS-1:0] frame_value_reg, slot_packed;
  logic                    frame_valid_reg, frame_err_reg;
  logic [NUM_DIGITS-1:0]   digit_err_reg;

  logic [6:0]              seg;
  logic [3:0]              nibble;
  logic                    illegal;
  logic [NUM_DIGITS-1:0]   dig_act, hit;
  logic                    sel_valid, changed, capture, frame_done;

  assign seg     = ~seg_n;
  assign dig_act = ~dig_n;
  // Exactly one active enable: nonzero and clearing its lowest set bit leaves zero.
  assign sel_valid = (dig_act != '0) && ((dig_act & (dig_act - DONE)) == '0);
  assign changed   = (seg_n != prev_seg_reg) || (dig_n != prev_dig_reg);

  always_comb begin
    nibble  = 4'h0;
    illegal = 1'b0;
    case (seg)
      7'h3F: nibble = 4'h0;
      7'h06: nibble = 4'h1;
      7'h5B: nibble = 4'h2;
      7'h4F: nibble = 4'h3;
      7'h66: nibble = 4'h4;
      7'h6D: nibble = 4'h5;
      7'h7D: nibble = 4'h6;
      7'h07: nibble = 4'h7;
      7'h7F: nibble = 4'h8;
      7'h67: nibble = 4'h9;
      7'h77: nibble = 4'hA;
      7'h7C: nibble = 4'hB;
      7'h58: nibble = 4'hC;
      7'h5E: nibble = 4'hD;
      7'h79: nibble = 4'hE;
      7'h71: nibble = 4'hF;
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    cnt_next = '0;
    if (sel_valid) begin
      if (changed)
        cnt_next = CW'(1);
      else if (cnt_reg < CMAX)
        cnt_next = cnt_reg + 1'b1;
      else
        cnt_next = cnt_reg;
    end
  end

  // A change edge reaching CMAX only happens when STABLE_CYCLES is 1.
  assign capture    = sel_valid && (cnt_next == CMAX) && (changed || (cnt_reg != CMAX));
  assign hit        = capture ? dig_act : '0;
  assign cap_or     = cap_reg | hit;
  assign frame_done = capture && (&cap_or);
  assign cap_next   = frame_done ? '0 : cap_or;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
    assign slot_next[gi]          = hit[gi] ? nibble : slot_reg[gi];
    assign err_next[gi]           = hit[gi] ? illegal : err_reg[gi];
    assign slot_packed[4*gi +: 4] = slot_next[gi];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_seg_reg    <= 7'h7F;
      prev_dig_reg    <= '1;
      cnt_reg         <= '0;
      err_reg         <= '0;
      cap_reg         <= '0;
      frame_value_reg <= '0;
      frame_valid_reg <= 1'b0;
      frame_err_reg   <= 1'b0;
      digit_err_reg   <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) slot_reg[i] <= 4'h0;
    end else begin
      prev_seg_reg    <= seg_n;
      prev_dig_reg    <= dig_n;
      cnt_reg         <= cnt_next;
      err_reg         <= err_next;
      cap_reg         <= cap_next;
      frame_valid_reg <= frame_done;
      for (int i = 0; i < NUM_DIGITS; i++) slot_reg[i] <= slot_next[i];
      if (frame_done) begin
        frame_value_reg <= slot_packed;
        digit_err_reg   <= err_next;
        frame_err_reg   <= |err_next;
      end
    end
  end

  assign frame_value = frame_value_reg;
  assign frame_valid = frame_valid_reg;
  assign frame_err   = frame_err_reg;
  assign digit_err   = digit_err_reg;

endmodule
